mul16_seq: RTL and testbench
============================

MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 Parameters: none; operand width fixed at 16, product width fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a multiply; sampled on rising edge of clk.
REQ-005 A  input  16  multiplicand (unsigned); captured when start is accepted.
REQ-006 B  input  16  multiplier (unsigned); captured when start is accepted.
REQ-007 busy  output  1  high while a multiply is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 P  output  32  product, registered.
REQ-010 ovf  output  1  high when P[31:16] != 0, i.e. product does not fit in 16 bits; registered with P.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-012 IDLE: start=1 at edge E0 -> RUN; mcand<=A, {hi,lo}<={16'h0,B}, count<=0; else hold.
REQ-013 RUN: each edge, sum17 = hi + (lo[0] ? mcand : 0), carry-in 0, 17-bit result incl. carry-out.
REQ-014 RUN: same edge, {hi,lo} <= {sum17,lo[15:1]} (33-bit right shift of {carry,sum,lo}); count<=count+1.
REQ-015 RUN: on edge where count==15 (16th RUN edge, E16) -> DONE; P<={hi,lo} final value; ovf<=|P[31:16].
REQ-016 DONE: done=1 for exactly that one cycle; next edge -> IDLE unconditionally.
REQ-017 Latency SHALL be fixed: start accepted at E0, done high in the cycle following E16, independent of operand values.
REQ-018 busy SHALL be 1 exactly in RUN (cycles after E0 through E16), 0 in IDLE and DONE.
REQ-019 start SHALL be ignored in RUN and DONE; A/B changes after E0 SHALL NOT affect the result.
REQ-020 Earliest accepted new start: the edge leaving DONE is not an acceptance edge; start is accepted on the first edge where state is IDLE.
REQ-021 P and ovf SHALL hold their value from E16 until the E16 of the next operation; P is not updated during RUN.
REQ-022 Arithmetic SHALL be exact unsigned: P = A*B for all 2^32 operand pairs; adder carry-out SHALL never be dropped.
REQ-023 Count SHALL be 4 bits; no wrap occurs beyond 15 since state leaves RUN at count==15.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, P=0, ovf=0, count=0, hi/lo/mcand=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-026 After rst_n rises, the first edge with start=1 SHALL be accepted.

Structure
REQ-027 Shared package/header SHALL hold: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), operand width 16, iteration count 16.
REQ-028 The 16-bit add SHALL be a single instance of the existing cla16 adder (C=0, carry-out as bit 16); no other sub-modules.
REQ-029 Unused state encoding 2'd3 SHALL transition to IDLE.

Verification
REQ-030 A=3, B=5, start at E0 -> busy E1..E16, done pulse after E16, P=32'h0000000F, ovf=0.
REQ-031 A=16'hFFFF, B=16'hFFFF -> P=32'hFFFE0001, ovf=1 (exercises carry-out every iteration).
REQ-032 A=16'h1234, B=0 -> P=0, ovf=0, done still after E16; then A=0, B=16'hFFFF -> P=0.
REQ-033 start=1 held continuously with A=2, B=7, A/B changed to 9/9 during RUN -> P=14; next op accepted first IDLE edge -> P=81.
REQ-034 rst_n pulsed low at E8 of A=100, B=200 -> P=0, busy=0 immediately; no done; new op A=100, B=200 -> P=32'd20000.
REQ-035 Random unsigned pairs (>=1000) vs. reference model P=A*B, ovf=(A*B>16'hFFFF), latency checked each op.

Source files
------------

// File: rtl/mul16_seq_pkg.sv
// Shared constants and state encoding for the 16x16 shift-and-add multiplier.
package mul16_seq_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int ITERS  = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul16_seq_if.sv
// Request/response bundle of the sequential multiplier: operands in, product out.
interface mul16_seq_if;
   import mul16_seq_pkg::*;

   logic              start;
   logic [OP_W-1:0]   A;
   logic [OP_W-1:0]   B;
   logic              busy;
   logic              done;
   logic [PROD_W-1:0] P;
   logic              ovf;

   modport master (output start, A, B, input busy, done, P, ovf);
   modport slave  (input start, A, B, output busy, done, P, ovf);
endinterface

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: 4-bit groups with group generate/propagate.
module cla16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c,
   output logic [15:0] s,
   output logic        co
);
   logic [15:0] g, p;
   logic [16:0] cy;
   logic [3:0]  gg, gp;
   logic [4:0]  gc;

   assign g = a & b;
   assign p = a ^ b;

   // Group carries are resolved first so each nibble only ripples internally.
   always_comb begin
      gg = '0;
      gp = '0;
      gc = '0;
      cy = '0;
      gc[0] = c;
      for (int k = 0; k < 4; k++) begin
         gp[k] = &p[4*k +: 4];
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      end
      for (int k = 0; k < 4; k++) begin
         cy[4*k] = gc[k];
         for (int i = 4*k; i < 4*k+3; i++) cy[i+1] = g[i] | (p[i] & cy[i]);
      end
      cy[16] = gc[4];
   end

   assign s  = p ^ cy[15:0];
   assign co = cy[16];
endmodule

// File: rtl/mul16_seq.sv
// Unsigned 16x16 multiplier, one partial product per clock, fixed 16-cycle latency.
module mul16_seq
   import mul16_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   mul16_seq_if.slave bus
);
   state_t            state;
   logic [OP_W-1:0]   mcand, hi, lo;
   logic [CNT_W-1:0]  count;
   logic [OP_W-1:0]   addend, sum;
   logic              carry;
   logic              busy_q, done_q, ovf_q;
   logic [PROD_W-1:0] p_q;

   assign addend = lo[0] ? mcand : '0;

   cla16 u_add (
      .a  (hi),
      .b  (addend),
      .c  (1'b0),
      .s  (sum),
      .co (carry)
   );

   // NOTE: every register here is updated with <= so all of them sample the
   // pre-edge values of each other; reset is asynchronous and clears all state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         hi     <= '0;
         lo     <= '0;
         count  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         p_q    <= '0;
         ovf_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state  <= RUN;
                  mcand  <= bus.A;
                  hi     <= '0;
                  lo     <= bus.B;
                  count  <= '0;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               // {carry,sum,lo} shifted right by one keeps the adder carry-out.
               hi    <= {carry, sum[OP_W-1:1]};
               lo    <= {sum[0], lo[OP_W-1:1]};
               count <= count + CNT_W'(1);
               if (count == CNT_W'(ITERS - 1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  p_q    <= {carry, sum, lo[OP_W-1:1]};
                  ovf_q  <= |{carry, sum[OP_W-1:1]};
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.P    = p_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: directed table, corner sequences, random ops.
module tb_mul16_seq;
   logic clk;
   logic rst_n;
   mul16_seq_if bus ();

   mul16_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp_p;
      logic        exp_ovf;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_p = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Called at the negedge following the accepting edge; returns at the done negedge.
   task automatic wait_done(input bit noise, output int lat);
      bit busy_ok = 1'b1;
      bit hold_ok = 1'b1;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (bus.P !== model_p) hold_ok = 1'b0;
         if (noise) begin
            bus.start = 1'($urandom);
            bus.A     = 16'($urandom);
            bus.B     = 16'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'd16);
      check("busy_in_run", 64'(busy_ok), 64'd1);
      check("p_hold_in_run", 64'(hold_ok), 64'd1);
      check("busy_at_done", 64'(bus.busy), 64'd0);
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit noise);
      int          lat;
      logic [31:0] exp_p;
      exp_p     = 32'(a) * 32'(b);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(noise, lat);
      check("product", 64'(bus.P), 64'(exp_p));
      check("ovf", 64'(bus.ovf), 64'(exp_p > 32'hFFFF));
      model_p   = exp_p;
      bus.start = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      check("done_pulse", 64'(bus.done), 64'd0);
      check("idle_after_done", 64'(bus.busy), 64'd0);
      bus.start = 1'b0;
   endtask

   vec_t vecs [8];

   initial begin
      int          lat;
      logic [15:0] ra, rb;
      bit          saw_done;

      vecs[0] = '{16'd3,      16'd5,      32'h0000000F, 1'b0};
      vecs[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001, 1'b1};
      vecs[2] = '{16'h1234,   16'h0000,   32'h00000000, 1'b0};
      vecs[3] = '{16'h0000,   16'hFFFF,   32'h00000000, 1'b0};
      vecs[4] = '{16'h0001,   16'hFFFF,   32'h0000FFFF, 1'b0};
      vecs[5] = '{16'h0100,   16'h0100,   32'h00010000, 1'b1};
      vecs[6] = '{16'd100,    16'd200,    32'd20000,    1'b0};
      vecs[7] = '{16'hFFFF,   16'h0001,   32'h0000FFFF, 1'b0};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_p", 64'(bus.P), 64'd0);
      check("rst_ovf", 64'(bus.ovf), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         bus.start = 1'b1;
         bus.A     = vecs[i].a;
         bus.B     = vecs[i].b;
         @(negedge clk);
         bus.start = 1'b0;
         wait_done(1'b0, lat);
         check($sformatf("vec%0d_p", i), 64'(bus.P), 64'(vecs[i].exp_p));
         check($sformatf("vec%0d_ovf", i), 64'(bus.ovf), 64'(vecs[i].exp_ovf));
         model_p = vecs[i].exp_p;
         @(negedge clk);
         check($sformatf("vec%0d_pulse", i), 64'(bus.done), 64'd0);
      end

      // start held high, operands changed mid-run, back-to-back acceptance
      bus.start = 1'b1;
      bus.A     = 16'd2;
      bus.B     = 16'd7;
      @(negedge clk);
      bus.A = 16'd9;
      bus.B = 16'd9;
      wait_done(1'b0, lat);
      check("held_start_p", 64'(bus.P), 64'd14);
      model_p = 32'd14;
      @(negedge clk);
      check("leave_done_not_accept", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check("first_idle_accept", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      wait_done(1'b0, lat);
      check("second_op_p", 64'(bus.P), 64'd81);
      model_p = 32'd81;
      @(negedge clk);

      // asynchronous reset in the middle of a run
      bus.start = 1'b1;
      bus.A     = 16'd100;
      bus.B     = 16'd200;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrun_rst_busy", 64'(bus.busy), 64'd0);
      check("midrun_rst_p", 64'(bus.P), 64'd0);
      check("midrun_rst_done", 64'(bus.done), 64'd0);
      model_p = '0;
      @(negedge clk);
      rst_n    = 1'b1;
      saw_done = 1'b0;
      repeat (24) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      end
      check("no_done_after_rst", 64'(saw_done), 64'd0);
      run_op(16'd100, 16'd200, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 7))
            0:       ra = 16'hFFFF;
            1:       ra = 16'h0000;
            default: ra = 16'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 16'hFFFF;
            1:       rb = 16'h0000;
            default: rb = 16'($urandom);
         endcase
         run_op(ra, rb, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
